// File: rtl/intctrl_arb_riscv.sv
// N-source interrupt controller: per-source edge/level latching, mie masking,
// fixed-priority or round-robin arbitration, and a GRANT/WAIT/DONE handshake with the core.

module intctrl_arb_riscv_src #(
   parameter bit EDGE = 1'b0
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic sreq,
   input  logic clr,
   output logic pend
);
   logic sreq_q, edge_q;

   // A new edge wins over a clear on the same cycle so back-to-back pulses are never lost.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sreq_q <= 1'b0;
         edge_q <= 1'b0;
      end else begin
         sreq_q <= sreq;
         edge_q <= (sreq & ~sreq_q) | (edge_q & ~clr);
      end
   end

   assign pend = EDGE ? edge_q : sreq;
endmodule

module intctrl_arb_riscv #(
   parameter int               N_SRC       = 16,
   parameter logic [N_SRC-1:0] EDGE_MASK   = '0,
   parameter bit               RR_MODE     = 1'b0,
   parameter int               SYNC_STAGES = 2,
   parameter int               CAUSE_BASE  = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [N_SRC-1:0] int_req_i,
   input  logic [N_SRC-1:0] mie_i,
   input  logic             int_fin_i,
   output logic             int_o,
   output logic [31:0]      mcause_o,
   output logic [N_SRC-1:0] int_fin_o,
   output logic             busy_o,
   output logic [N_SRC-1:0] pending_o
);
   localparam int IDW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

   typedef enum logic [1:0] {S_IDLE, S_GRANT, S_WAIT, S_DONE} state_t;

   state_t           state, state_n;
   logic [N_SRC-1:0] sreq, pend, eligible;
   logic [IDW-1:0]   id_q, last_grant, win;
   logic [4:0]       cause_lo;
   int               rr_idx;

   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign sreq = int_req_i;
      end else begin : g_sync
         logic [SYNC_STAGES-1:0][N_SRC-1:0] sync_q;
         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               sync_q <= '0;
            end else begin
               sync_q[0] <= int_req_i;
               for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            end
         end
         assign sreq = sync_q[SYNC_STAGES-1];
      end

      for (genvar i = 0; i < N_SRC; i++) begin : g_src
         intctrl_arb_riscv_src #(.EDGE(EDGE_MASK[i])) u_src (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .sreq   (sreq[i]),
            .clr    (int_fin_o[i]),
            .pend   (pend[i])
         );
      end
   endgenerate

   // Level sources follow the raw synchronised line, so force the visible vector low in reset.
   assign pending_o = rst_ni ? pend : '0;
   assign eligible  = pend & mie_i;

   always_comb begin
      win    = '0;
      rr_idx = 0;
      if (RR_MODE) begin
         for (int k = N_SRC; k >= 1; k--) begin
            rr_idx = (int'(last_grant) + k) % N_SRC;
            if (eligible[rr_idx]) win = IDW'(rr_idx);
         end
      end else begin
         for (int i = N_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) win = IDW'(i);
         end
      end
   end

   assign cause_lo = 5'(CAUSE_BASE) + 5'(win);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state      <= S_IDLE;
         id_q       <= '0;
         mcause_o   <= '0;
         last_grant <= IDW'(N_SRC - 1);
      end else begin
         state <= state_n;
         if (state == S_IDLE && |eligible) begin
            id_q     <= win;
            mcause_o <= {1'b1, 26'b0, cause_lo};
         end
         if (state == S_DONE) last_grant <= id_q;
      end
   end

   always_comb begin
      state_n   = state;
      int_o     = 1'b0;
      int_fin_o = '0;
      busy_o    = 1'b1;
      case (state)
         S_IDLE: begin
            busy_o = 1'b0;
            if (|eligible) state_n = S_GRANT;
         end
         S_GRANT: begin
            int_o   = 1'b1;
            state_n = int_fin_i ? S_DONE : S_WAIT;
         end
         S_WAIT: begin
            if (int_fin_i) state_n = S_DONE;
         end
         S_DONE: begin
            int_fin_o = N_SRC'(1) << id_q;
            state_n   = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end
endmodule

// File: tb/tb_intctrl_arb_riscv.sv
// Scoreboard bench: stimulus pushes expected int/fin events, a monitor pops and compares.

module tb_intctrl_arb_riscv;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // dut0: fixed priority, no sync, source 4 edge
   logic [15:0] req0 = '0, mie0 = '0, fino0, pend0;
   logic        fin0 = 1'b0, io0, busy0;
   logic [31:0] mc0;
   // dut1: round-robin, two sync stages
   logic [15:0] req1 = '0, mie1 = '0, fino1, pend1;
   logic        fin1 = 1'b0, io1, busy1;
   logic [31:0] mc1;
   // dut2: 32 sources
   logic [31:0] req2 = '0, mie2 = '0, fino2, pend2;
   logic        fin2 = 1'b0, io2, busy2;
   logic [31:0] mc2;
   // dut3: single source
   logic [0:0]  req3 = '0, mie3 = '0, fino3, pend3;
   logic        fin3 = 1'b0, io3, busy3;
   logic [31:0] mc3;

   intctrl_arb_riscv #(.N_SRC(16), .EDGE_MASK(16'h0010), .RR_MODE(1'b0), .SYNC_STAGES(0), .CAUSE_BASE(16)) u_dut0 (
      .clk_i(clk), .rst_ni(rst_n), .int_req_i(req0), .mie_i(mie0), .int_fin_i(fin0),
      .int_o(io0), .mcause_o(mc0), .int_fin_o(fino0), .busy_o(busy0), .pending_o(pend0));
   intctrl_arb_riscv #(.N_SRC(16), .EDGE_MASK(16'h0000), .RR_MODE(1'b1), .SYNC_STAGES(2), .CAUSE_BASE(16)) u_dut1 (
      .clk_i(clk), .rst_ni(rst_n), .int_req_i(req1), .mie_i(mie1), .int_fin_i(fin1),
      .int_o(io1), .mcause_o(mc1), .int_fin_o(fino1), .busy_o(busy1), .pending_o(pend1));
   intctrl_arb_riscv #(.N_SRC(32), .EDGE_MASK(32'h0), .RR_MODE(1'b0), .SYNC_STAGES(0), .CAUSE_BASE(16)) u_dut2 (
      .clk_i(clk), .rst_ni(rst_n), .int_req_i(req2), .mie_i(mie2), .int_fin_i(fin2),
      .int_o(io2), .mcause_o(mc2), .int_fin_o(fino2), .busy_o(busy2), .pending_o(pend2));
   intctrl_arb_riscv #(.N_SRC(1), .EDGE_MASK(1'b0), .RR_MODE(1'b0), .SYNC_STAGES(0), .CAUSE_BASE(16)) u_dut3 (
      .clk_i(clk), .rst_ni(rst_n), .int_req_i(req3), .mie_i(mie3), .int_fin_i(fin3),
      .int_o(io3), .mcause_o(mc3), .int_fin_o(fino3), .busy_o(busy3), .pending_o(pend3));

   typedef struct {
      int          dut;
      bit          fin;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   t_grant[$];

   task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input int d, input bit f, input logic [31:0] v);
      exp_t e;
      e.dut = d; e.fin = f; e.val = v;
      sb.push_back(e);
   endtask

   task automatic match(input int d, input bit f, input logic [31:0] v);
      int idx = -1;
      for (int k = 0; k < sb.size(); k++) begin
         if (idx < 0 && sb[k].dut == d) idx = k;
      end
      if (idx < 0) begin
         chk($sformatf("dut%0d spurious %s", d, f ? "fin" : "int"), {1'b1, v}, 33'd0);
      end else begin
         chk($sformatf("dut%0d %s", d, f ? "fin" : "int"), {f, v}, {sb[idx].fin, sb[idx].val});
         sb.delete(idx);
      end
   endtask

   task automatic mon(input int d, input logic io, input logic [31:0] mc, input logic [31:0] fo);
      if (io) match(d, 1'b0, mc);
      if (fo != 0) match(d, 1'b1, fo);
   endtask

   task automatic monitor();
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (io1) t_grant.push_back(cyc);
            mon(0, io0, mc0, 32'(fino0));
            mon(1, io1, mc1, 32'(fino1));
            mon(2, io2, mc2, fino2);
            mon(3, io3, mc3, 32'(fino3));
         end
      end
   endtask

   function automatic logic io_of(input int d);
      case (d)
         0:       return io0;
         1:       return io1;
         2:       return io2;
         default: return io3;
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_int(input int d, output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!io_of(d) && n < 50);
      if (!io_of(d)) chk($sformatf("dut%0d int timeout", d), 33'(io_of(d)), 33'd1);
   endtask

   // Serve the presented dut0 interrupt: optional WAIT delay, drop served lines, optional pulse in DONE.
   task automatic serve0(input logic [15:0] clr, input int dly, input logic [15:0] pulse);
      int n;
      wait_int(0, n);
      repeat (dly) step();
      fin0 = 1'b1;
      req0 = req0 & ~clr;
      step();
      fin0 = 1'b0;
      if (pulse != 0) begin
         req0 = req0 | pulse;
         step();
         req0 = req0 & ~pulse;
      end
   endtask

   initial begin
      int n, cnt;
      fork monitor(); join_none

      // reset state
      repeat (3) step();
      chk("rst int_o", 33'(io0), 33'd0);
      chk("rst busy", 33'(busy0), 33'd0);
      chk("rst mcause", 33'(mc0), 33'd0);
      chk("rst int_fin", 33'(fino0), 33'd0);
      chk("rst pending", 33'(pend0), 33'd0);
      rst_n = 1'b1;
      step();

      // fixed priority: 3 beats 5
      push(0, 0, 32'h8000_0013); push(0, 1, 32'h0008);
      push(0, 0, 32'h8000_0015); push(0, 1, 32'h0020);
      mie0 = 16'hFFFF;
      req0 = 16'h0028;
      wait_int(0, n);
      chk("fp latency", 33'(n), 33'd1);
      fin0 = 1'b1; req0 = req0 & ~16'h0008;
      step();
      fin0 = 1'b0;
      serve0(16'h0020, 2, 16'h0);
      step(); step();
      chk("mcause hold", 33'(mc0), 33'h0_8000_0015);
      chk("idle busy", 33'(busy0), 33'd0);

      // edge source 4 pulsed while busy on 1, then re-pulsed in its own DONE
      push(0, 0, 32'h8000_0011);
      req0 = 16'h0002;
      wait_int(0, n);
      step();
      req0 = req0 | 16'h0010;
      step();
      req0 = req0 & ~16'h0010;
      step();
      chk("edge pend held", 33'(pend0[4]), 33'd1);
      chk("wait busy", 33'(busy0), 33'd1);
      push(0, 1, 32'h0002);
      push(0, 0, 32'h8000_0014); push(0, 1, 32'h0010);
      push(0, 0, 32'h8000_0014); push(0, 1, 32'h0010);
      fin0 = 1'b1; req0 = req0 & ~16'h0002;
      step();
      fin0 = 1'b0;
      serve0(16'h0, 0, 16'h0010);
      serve0(16'h0, 1, 16'h0);
      step();
      chk("edge pend clear", 33'(pend0), 33'd0);

      // mie masking
      mie0 = 16'hFF7F;
      req0 = 16'h0080;
      cnt = 0;
      repeat (20) begin
         step();
         if (io0) cnt++;
      end
      chk("masked no int", 33'(cnt), 33'd0);
      chk("masked pending", 33'(pend0), 33'h0080);
      push(0, 0, 32'h8000_0017); push(0, 1, 32'h0080);
      mie0 = 16'hFFFF;
      wait_int(0, n);
      chk("unmask latency", 33'(n), 33'd1);
      step(); step();
      mie0 = 16'hFF7F;
      step();
      fin0 = 1'b1; req0 = '0;
      step();
      fin0 = 1'b0;
      step();
      mie0 = 16'hFFFF;

      // async reset mid-WAIT
      push(0, 0, 32'h8000_0017);
      req0 = 16'h0080;
      wait_int(0, n);
      step(); step();
      #2 rst_n = 1'b0;
      #1;
      chk("arst int_o", 33'(io0), 33'd0);
      chk("arst busy", 33'(busy0), 33'd0);
      chk("arst mcause", 33'(mc0), 33'd0);
      chk("arst int_fin", 33'(fino0), 33'd0);
      chk("arst pending", 33'(pend0), 33'd0);
      req0 = '0;
      step(); step();
      rst_n = 1'b1;
      cnt = 0;
      repeat (10) begin
         step();
         if (fino0 != 0) cnt++;
      end
      chk("no fin after reset", 33'(cnt), 33'd0);

      // round-robin over 0/1/2, fin given in GRANT
      push(1, 0, 32'h8000_0010); push(1, 1, 32'h0001);
      push(1, 0, 32'h8000_0011); push(1, 1, 32'h0002);
      push(1, 0, 32'h8000_0012); push(1, 1, 32'h0004);
      push(1, 0, 32'h8000_0010); push(1, 1, 32'h0001);
      mie1 = 16'hFFFF;
      req1 = 16'h0007;
      for (int g = 0; g < 4; g++) begin
         wait_int(1, n);
         fin1 = 1'b1;
         if (g == 3) req1 = '0;
         step();
         fin1 = 1'b0;
      end
      repeat (6) step();
      chk("rr grant count", 33'(t_grant.size()), 33'd4);
      for (int g = 1; g < 4 && g < t_grant.size(); g++)
         chk($sformatf("rr spacing %0d", g), 33'(t_grant[g] - t_grant[g-1]), 33'd3);

      // top source on N_SRC=32 and N_SRC=1 builds
      push(2, 0, 32'h8000_000F); push(2, 1, 32'h8000_0000);
      push(3, 0, 32'h8000_0010); push(3, 1, 32'h0000_0001);
      mie2 = '1; mie3 = 1'b1;
      req2 = 32'h8000_0000; req3 = 1'b1;
      wait_int(2, n);
      fin2 = 1'b1; fin3 = 1'b1;
      req2 = '0; req3 = '0;
      step();
      fin2 = 1'b0; fin3 = 1'b0;
      repeat (5) step();

      chk("scoreboard drained", 33'(sb.size()), 33'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global timeout at cycle %0d", cyc);
      $fatal(1, "timeout");
   end
endmodule
